// File: rtl/dq_train_pkg.sv
// Shared types and constants for the DQ read-eye training controller.
// Optional DQ_TRAIN_WIN_REPORT_EN adds a per-lane window length report.
package dq_train_pkg;

    localparam int TAP_W = 5;
    localparam logic [TAP_W-1:0] TAP_MAX = 5'd31;
    localparam logic [7:0] MPR_PATTERN = 8'h55;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_CHECK,
        S_NEXT_TAP,
        S_CTR_LOAD,
        S_CTR_SETTLE,
        S_NEXT_LANE,
        S_DONE
    } state_t;

endpackage

// File: rtl/dq_win_track.sv
// Run/best passing-window tracker for one lane's tap sweep.
// Strict compare keeps the lowest-start window on ties.
module dq_win_track
    import dq_train_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             upd_i,
    input  logic             pass_i,
    input  logic [TAP_W-1:0] tap_i,
    output logic [TAP_W-1:0] best_start_o,
    output logic [5:0]       best_len_o
);

    logic [TAP_W-1:0] run_start_q, run_start_d, run_start_n;
    logic [TAP_W-1:0] best_start_q, best_start_d;
    logic [5:0]       run_len_q, run_len_d, run_len_n;
    logic [5:0]       best_len_q, best_len_d;

    assign run_len_n   = run_len_q + 6'd1;
    assign run_start_n = (run_len_q == 6'd0) ? tap_i : run_start_q;

    always_comb begin
        run_start_d  = run_start_q;
        run_len_d    = run_len_q;
        best_start_d = best_start_q;
        best_len_d   = best_len_q;
        if (clr_i) begin
            run_start_d  = '0;
            run_len_d    = '0;
            best_start_d = '0;
            best_len_d   = '0;
        end else if (upd_i) begin
            if (pass_i) begin
                run_start_d = run_start_n;
                run_len_d   = run_len_n;
                if (run_len_n > best_len_q) begin
                    best_start_d = run_start_n;
                    best_len_d   = run_len_n;
                end
            end else begin
                run_len_d = '0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            run_start_q  <= '0;
            run_len_q    <= '0;
            best_start_q <= '0;
            best_len_q   <= '0;
        end else begin
            run_start_q  <= run_start_d;
            run_len_q    <= run_len_d;
            best_start_q <= best_start_d;
            best_len_q   <= best_len_d;
        end
    end

    assign best_start_o = best_start_q;
    assign best_len_o   = best_len_q;

endmodule

// File: rtl/dq_delay_train.sv
// Per-bit read-eye training: sweeps IDELAY taps per lane, loads window centre.
// Define DQ_TRAIN_WIN_REPORT_EN to add the win_len output.
module dq_delay_train
    import dq_train_pkg::*;
#(
    parameter int         W       = 2,
    parameter int         SETTLE  = 16,
    parameter int         SAMPLES = 64,
    parameter int         MIN_WIN = 4,
    parameter logic [7:0] PATTERN = MPR_PATTERN
) (
    input  logic                 divclk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [W*64-1:0]      rd_data,
    output logic [TAP_W-1:0]     cntvaluein,
    output logic [W*8-1:0]       ld,
    output logic                 busy,
    output logic                 done,
    output logic [W*8-1:0]       lane_err,
`ifdef DQ_TRAIN_WIN_REPORT_EN
    output logic [W*8*6-1:0]     win_len,
`endif
    output logic [W*8*TAP_W-1:0] tap_out
);

    localparam int L  = W * 8;
    localparam int LW = (L > 1) ? $clog2(L) : 1;
    localparam logic [7:0]    SETTLE_LAST = 8'(SETTLE - 1);
    localparam logic [7:0]    SAMP_LAST   = 8'(SAMPLES - 1);
    localparam logic [LW-1:0] LANE_LAST   = LW'(L - 1);
    localparam logic [5:0]    MINW        = 6'(MIN_WIN);

    state_t              state_q, state_d;
    logic [LW-1:0]       lane_q, lane_d;
    logic [TAP_W-1:0]    tap_q, tap_d, cv_q, center;
    logic [7:0]          cnt_q, cnt_d, word;
    logic                pass_q, pass_d;
    logic [L-1:0]        err_q, err_d;
    logic [L*TAP_W-1:0]  tapo_q, tapo_d;
    logic [TAP_W-1:0]    best_start;
    logic [5:0]          best_len;
    logic                accept, word_ok, lane_bad;

    assign accept   = start && (state_q == S_IDLE || state_q == S_DONE);
    assign word     = rd_data[{lane_q, 3'b000} +: 8];
    assign word_ok  = (word == PATTERN);
    assign lane_bad = (best_len < MINW);
    assign center   = lane_bad ? '0 : best_start + best_len[5:1];

    dq_win_track u_win (
        .clk_i        (divclk),
        .rst_ni       (reset_n),
        .clr_i        (accept || state_q == S_NEXT_LANE),
        .upd_i        (state_q == S_NEXT_TAP),
        .pass_i       (pass_q),
        .tap_i        (tap_q),
        .best_start_o (best_start),
        .best_len_o   (best_len)
    );

    always_ff @(posedge divclk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_DONE: if (start) state_d = S_LOAD;
            S_LOAD:         state_d = S_SETTLE;
            S_SETTLE:       if (cnt_q == SETTLE_LAST) state_d = S_CHECK;
            S_CHECK: begin
                if (!word_ok || cnt_q == SAMP_LAST) state_d = S_NEXT_TAP;
            end
            S_NEXT_TAP: begin
                state_d = (tap_q == TAP_MAX) ? S_CTR_LOAD : S_LOAD;
            end
            S_CTR_LOAD:     state_d = S_CTR_SETTLE;
            S_CTR_SETTLE:   if (cnt_q == SETTLE_LAST) state_d = S_NEXT_LANE;
            S_NEXT_LANE: begin
                state_d = (lane_q == LANE_LAST) ? S_DONE : S_LOAD;
            end
            default:        state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ld         = '0;
        cntvaluein = cv_q;
        busy       = !(state_q == S_IDLE || state_q == S_DONE);
        done       = (state_q == S_DONE);
        if (state_q == S_LOAD) begin
            cntvaluein = tap_q;
            ld[lane_q] = 1'b1;
        end else if (state_q == S_CTR_LOAD) begin
            cntvaluein = center;
            ld[lane_q] = 1'b1;
        end
    end

    assign lane_err = err_q;
    assign tap_out  = tapo_q;

    // cnt_q is shared by both settle waits and the sample run
    always_comb begin
        lane_d = lane_q;
        tap_d  = tap_q;
        cnt_d  = '0;
        pass_d = pass_q;
        err_d  = err_q;
        tapo_d = tapo_q;
        if (accept) begin
            lane_d = '0;
            tap_d  = '0;
            err_d  = '0;
            tapo_d = '0;
        end
        unique case (state_q)
            S_SETTLE, S_CTR_SETTLE: begin
                if (cnt_q != SETTLE_LAST) cnt_d = cnt_q + 8'd1;
            end
            S_CHECK: begin
                pass_d = word_ok;
                if (word_ok && cnt_q != SAMP_LAST) cnt_d = cnt_q + 8'd1;
            end
            S_NEXT_TAP: if (tap_q != TAP_MAX) tap_d = tap_q + 1'b1;
            S_CTR_LOAD: begin
                err_d[lane_q] = lane_bad;
                tapo_d[int'(lane_q)*TAP_W +: TAP_W] = center;
            end
            S_NEXT_LANE: begin
                if (lane_q != LANE_LAST) begin
                    lane_d = lane_q + 1'b1;
                    tap_d  = '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge divclk or negedge reset_n) begin
        if (!reset_n) begin
            lane_q <= '0;
            tap_q  <= '0;
            cnt_q  <= '0;
            pass_q <= 1'b0;
            err_q  <= '0;
            tapo_q <= '0;
            cv_q   <= '0;
        end else begin
            lane_q <= lane_d;
            tap_q  <= tap_d;
            cnt_q  <= cnt_d;
            pass_q <= pass_d;
            err_q  <= err_d;
            tapo_q <= tapo_d;
            cv_q   <= cntvaluein;
        end
    end

`ifdef DQ_TRAIN_WIN_REPORT_EN
    logic [L*6-1:0] winl_q, winl_d;

    always_comb begin
        winl_d = winl_q;
        if (accept) winl_d = '0;
        if (state_q == S_CTR_LOAD) winl_d[int'(lane_q)*6 +: 6] = best_len;
    end

    always_ff @(posedge divclk or negedge reset_n) begin
        if (!reset_n) winl_q <= '0;
        else          winl_q <= winl_d;
    end

    assign win_len = winl_q;
`endif

endmodule

// File: tb/tb_dq_delay_train.sv
// Randomized bench for dq_delay_train against a window-search model.
module tb_dq_delay_train;

    localparam int W       = 2;
    localparam int L       = W * 8;
    localparam int SETTLE  = 16;
    localparam int SAMPLES = 64;
    localparam int MIN_WIN = 4;

    logic           divclk = 1'b0;
    logic           reset_n;
    logic           start;
    logic [L*8-1:0] rd_data;
    logic [4:0]     cntvaluein;
    logic [L-1:0]   ld;
    logic           busy;
    logic           done;
    logic [L-1:0]   lane_err;
    logic [L*5-1:0] tap_out;
`ifdef DQ_TRAIN_WIN_REPORT_EN
    logic [L*6-1:0] win_len;
`endif

    dq_delay_train dut (
        .divclk     (divclk),
        .reset_n    (reset_n),
        .start      (start),
        .rd_data    (rd_data),
        .cntvaluein (cntvaluein),
        .ld         (ld),
        .busy       (busy),
        .done       (done),
        .lane_err   (lane_err),
`ifdef DQ_TRAIN_WIN_REPORT_EN
        .win_len    (win_len),
`endif
        .tap_out    (tap_out)
    );

    always #5 divclk = ~divclk;

    // fidx[l][t]: sample index of the first mismatch, >= SAMPLES means pass
    int fidx [L][32];
    int cur_tap [L] = '{default: 0};
    int age [L] = '{default: 1000};

    int n_chk = 0;
    int n_pass = 0;
    int dur = 0;
    int trace_bad = 0;
    bit trace_on = 1'b0;
    bit m_busy = 1'b0;
    bit m_done = 1'b0;
    int m_left = 0;

    // IDELAY + DRAM model: mismatch on the chosen CHECK sample of the loaded tap
    always @(negedge divclk) begin
        for (int i = 0; i < L; i++) begin
            if (ld[i] === 1'b1) begin
                cur_tap[i] = int'(cntvaluein);
                age[i] = 0;
            end else if (age[i] < 100000) begin
                age[i]++;
            end
            if (fidx[i][cur_tap[i]] < SAMPLES &&
                age[i] == SETTLE + 1 + fidx[i][cur_tap[i]])
                rd_data[8*i +: 8] = ~8'h55;
            else
                rd_data[8*i +: 8] = 8'h55;
        end
    end

    always @(posedge divclk or negedge reset_n) begin
        if (!reset_n) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_left = 0;
        end else if (start && !m_busy) begin
            m_busy = 1'b1;
            m_done = 1'b0;
            m_left = dur;
        end else if (m_busy) begin
            if (m_left == 1) begin
                m_busy = 1'b0;
                m_done = 1'b1;
            end
            m_left--;
        end
    end

    always @(negedge divclk) begin
        if (trace_on && reset_n) begin
            if (busy !== m_busy || done !== m_done) trace_bad++;
            if ($countones(ld) > 1 || (ld != '0 && !busy)) trace_bad++;
        end
    end

    task automatic check(input string nm, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    endtask

    function automatic int tap_of(input int i);
        return int'(tap_out[5*i +: 5]);
    endfunction

    function automatic void model_lane(input int l, output int ctr, output int err);
        int bl = 0;
        int bs = 0;
        for (int s = 0; s < 32; s++) begin
            int n = 0;
            while (s + n < 32 && fidx[l][s+n] >= SAMPLES) n++;
            if (n > bl) begin
                bl = n;
                bs = s;
            end
        end
        err = (bl < MIN_WIN) ? 1 : 0;
        ctr = err ? 0 : bs + bl / 2;
    endfunction

    function automatic int model_dur();
        int d = 0;
        for (int l = 0; l < L; l++) begin
            for (int t = 0; t < 32; t++) begin
                int k = (fidx[l][t] >= SAMPLES) ? SAMPLES : fidx[l][t] + 1;
                d += 1 + SETTLE + k + 1;
            end
            d += 2 + SETTLE;
        end
        return d;
    endfunction

    task automatic set_win(input int l, input int lo, input int hi);
        for (int t = lo; t <= hi; t++) fidx[l][t] = SAMPLES;
    endtask

    task automatic run_train(input int inj, output int cyc);
        bit fin = 1'b0;
        @(negedge divclk);
        start = 1'b1;
        @(negedge divclk);
        start = 1'b0;
        check("clr_done", done, 0);
        check("clr_err", lane_err, 0);
        check("clr_tap", tap_out, 0);
        cyc = busy ? 1 : 0;
        for (int k = 0; k < 2 * dur + 100; k++) begin
            start = (k == inj);
            @(negedge divclk);
            if (done) begin
                fin = 1'b1;
                break;
            end
            if (busy) cyc++;
        end
        start = 1'b0;
        check("done_reached", fin, 1);
    endtask

    task automatic check_lanes();
        int c, e;
        for (int i = 0; i < L; i++) begin
            model_lane(i, c, e);
            check($sformatf("lane%0d_tap", i), tap_of(i), c);
            check($sformatf("lane%0d_err", i), lane_err[i], e);
        end
    endtask

    initial begin
        int cyc;
        int k;
        reset_n = 1'b0;
        start = 1'b0;
        for (int l = 0; l < L; l++)
            for (int t = 0; t < 32; t++) fidx[l][t] = SAMPLES;
        repeat (3) @(negedge divclk);
        check("rst_cv", cntvaluein, 0);
        check("rst_ld", ld, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", lane_err, 0);
        check("rst_tap", tap_out, 0);
        reset_n = 1'b1;
        trace_on = 1'b1;

        dur = model_dur();
        run_train(-1, cyc);
        check("run1_cycles", cyc, 42272);
        check("run1_tap0", tap_of(0), 16);
        check("run1_tap15", tap_of(15), 16);
        check_lanes();

        for (int l = 0; l < L; l++) begin
            for (int t = 0; t < 32; t++) begin
                if ($urandom_range(0, 3) == 0) fidx[l][t] = SAMPLES;
                else if ($urandom_range(0, 7) == 0) fidx[l][t] = 63;
                else fidx[l][t] = int'($urandom_range(0, 15));
            end
        end
        foreach (fidx[l, t])
            if (l inside {0, 3, 5, 7, 9, 11}) fidx[l][t] = 0;
        set_win(3, 10, 19);
        set_win(0, 2, 5);
        set_win(0, 20, 25);
        set_win(5, 0, 2);
        set_win(5, 6, 8);
        set_win(7, 28, 31);
        set_win(9, 28, 31);
        fidx[9][29] = 63;
        set_win(11, 4, 7);
        set_win(11, 12, 15);
        dur = model_dur();
        run_train(500, cyc);
        check("run2_cycles", cyc, dur);
        check("l3_tap", tap_of(3), 15);
        check("l3_err", lane_err[3], 0);
        check("l0_tap", tap_of(0), 23);
        check("l5_tap", tap_of(5), 0);
        check("l5_err", lane_err[5], 1);
        check("l7_tap", tap_of(7), 30);
        check("l7_err", lane_err[7], 0);
        check("l9_tap", tap_of(9), 0);
        check("l9_err", lane_err[9], 1);
        check("l11_tap", tap_of(11), 6);
        check_lanes();

        @(negedge divclk);
        start = 1'b1;
        @(negedge divclk);
        start = 1'b0;
        k = 0;
        while (ld[4] !== 1'b1 && k < 40000) begin
            @(negedge divclk);
            k++;
        end
        check("reach_lane4", ld[4], 1);
        repeat (40) @(negedge divclk);
        #2 reset_n = 1'b0;
        #1;
        check("abort_cv", cntvaluein, 0);
        check("abort_ld", ld, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_err", lane_err, 0);
        check("abort_tap", tap_out, 0);
        @(negedge divclk);
        reset_n = 1'b1;
        repeat (5) @(negedge divclk);
        check("idle_busy", busy, 0);
        check("idle_ld", ld, 0);
        check("trace", trace_bad, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
